// File: rtl/arithmetic_execute_unit_if.sv
// Shared operation/condition/flag types and the issue/result bundle of the
// integer ALU execute unit. The package precedes the interface so both the
// interface and the unit can reference its types.
package arithmetic_execute_unit_pkg;

    // Five bits wide so that unused encodings exist; those return zero.
    typedef enum logic [4:0] {
        ALU_PLUS   = 5'd0,
        ALU_MINUS  = 5'd1,
        ALU_AND    = 5'd2,
        ALU_OR     = 5'd3,
        ALU_EOR    = 5'd4,
        ALU_ORN    = 5'd5,
        ALU_MOV    = 5'd6,
        ALU_MOVK   = 5'd7,
        ALU_LSL    = 5'd8,
        ALU_LSR    = 5'd9,
        ALU_ASR    = 5'd10,
        ALU_CSEL   = 5'd11,
        ALU_CSINV  = 5'd12,
        ALU_CSINC  = 5'd13,
        ALU_CSNEG  = 5'd14,
        ALU_PASS_A = 5'd15
    } alu_op_t;

    // ARM condition-code encoding.
    typedef enum logic [3:0] {
        COND_EQ = 4'd0,  COND_NE = 4'd1,  COND_CS = 4'd2,  COND_CC = 4'd3,
        COND_MI = 4'd4,  COND_PL = 4'd5,  COND_VS = 4'd6,  COND_VC = 4'd7,
        COND_HI = 4'd8,  COND_LS = 4'd9,  COND_GE = 4'd10, COND_LT = 4'd11,
        COND_GT = 4'd12, COND_LE = 4'd13, COND_AL = 4'd14, COND_NV = 4'd15
    } cond_t;

    // {N,Z,C,V}
    typedef logic [3:0] nzcv_t;

endpackage

interface arithmetic_execute_unit_if;
    logic                                  in_start;
    arithmetic_execute_unit_pkg::alu_op_t  in_alu_op;
    logic [63:0]                           in_val_a;
    logic [63:0]                           in_val_b;
    logic [5:0]                            in_alu_val_hw;
    logic                                  in_set_CC;
    arithmetic_execute_unit_pkg::cond_t    in_cond;
    arithmetic_execute_unit_pkg::nzcv_t    in_prev_nzcv;
    logic [63:0]                           out_fu_value;
    arithmetic_execute_unit_pkg::nzcv_t    out_fu_nzcv;
    logic                                  out_cond_val;
    logic                                  out_fu_done;

    // Issuing side (reservation station).
    modport master (
        output in_start, in_alu_op, in_val_a, in_val_b, in_alu_val_hw,
               in_set_CC, in_cond, in_prev_nzcv,
        input  out_fu_value, out_fu_nzcv, out_cond_val, out_fu_done
    );

    // Execute unit side.
    modport slave (
        input  in_start, in_alu_op, in_val_a, in_val_b, in_alu_val_hw,
               in_set_CC, in_cond, in_prev_nzcv,
        output out_fu_value, out_fu_nzcv, out_cond_val, out_fu_done
    );
endinterface

// File: rtl/arithmetic_execute_unit.sv
// Single-cycle integer ALU for the execute stage: one micro-op per cycle,
// registered result/flags/condition one cycle after the issue edge.
// Build option: define ARITH_EU_SHIFT_EN to include the LSL/LSR/ASR shifter;
// without it those ops return zero.
module arithmetic_execute_unit
    import arithmetic_execute_unit_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,   // asynchronous, active-low
    arithmetic_execute_unit_if.slave eu
);

    logic [63:0] value_q, value_d;
    nzcv_t       nzcv_q,  nzcv_d;
    logic        cond_q,  cond_d;
    logic        done_q,  done_d;

    logic [63:0] op_a, op_b;
    logic [64:0] sum_w;     // a + b with carry out
    logic [64:0] diff_w;    // a + ~b + 1 with carry (1 = no borrow)
    logic [63:0] res_w;
    logic        c_w, v_w;
    logic        cond_w;
    logic        n_p, z_p, c_p, v_p;

    assign op_a   = eu.in_val_a;
    assign op_b   = eu.in_val_b;
    assign sum_w  = {1'b0, op_a} + {1'b0, op_b};
    assign diff_w = {1'b0, op_a} + {1'b0, ~op_b} + 65'd1;
    assign {n_p, z_p, c_p, v_p} = eu.in_prev_nzcv;

    // Condition evaluated on the incoming architectural flags only.
    always_comb begin
        cond_w = 1'b1;
        case (eu.in_cond)
            COND_EQ: cond_w = z_p;
            COND_NE: cond_w = !z_p;
            COND_CS: cond_w = c_p;
            COND_CC: cond_w = !c_p;
            COND_MI: cond_w = n_p;
            COND_PL: cond_w = !n_p;
            COND_VS: cond_w = v_p;
            COND_VC: cond_w = !v_p;
            COND_HI: cond_w = c_p && !z_p;
            COND_LS: cond_w = !(c_p && !z_p);
            COND_GE: cond_w = (n_p == v_p);
            COND_LT: cond_w = (n_p != v_p);
            COND_GT: cond_w = !z_p && (n_p == v_p);
            COND_LE: cond_w = !(!z_p && (n_p == v_p));
            default: cond_w = 1'b1;   // AL, NV
        endcase
    end

    // Result datapath plus carry/overflow for the add/subtract ops.
    always_comb begin
        res_w = '0;
        c_w   = 1'b0;
        v_w   = 1'b0;
        case (eu.in_alu_op)
            ALU_PLUS: begin
                res_w = sum_w[63:0];
                c_w   = sum_w[64];
                v_w   = (op_a[63] == op_b[63]) && (sum_w[63] != op_a[63]);
            end
            ALU_MINUS: begin
                res_w = diff_w[63:0];
                c_w   = diff_w[64];
                v_w   = (op_a[63] != op_b[63]) && (diff_w[63] != op_a[63]);
            end
            ALU_AND:    res_w = op_a & op_b;
            ALU_OR:     res_w = op_a | op_b;
            ALU_EOR:    res_w = op_a ^ op_b;
            ALU_ORN:    res_w = op_a | ~op_b;
            ALU_MOV:    res_w = op_b << eu.in_alu_val_hw;
            ALU_MOVK:   res_w = (op_a & ~(64'hFFFF << eu.in_alu_val_hw))
                              | ({48'd0, op_b[15:0]} << eu.in_alu_val_hw);
`ifdef ARITH_EU_SHIFT_EN
            ALU_LSL:    res_w = op_a << op_b[5:0];
            ALU_LSR:    res_w = op_a >> op_b[5:0];
            ALU_ASR:    res_w = $signed(op_a) >>> op_b[5:0];
`else
            ALU_LSL, ALU_LSR, ALU_ASR: res_w = '0;
`endif
            ALU_CSEL:   res_w = cond_w ? op_a : op_b;
            ALU_CSINV:  res_w = cond_w ? op_a : ~op_b;
            ALU_CSINC:  res_w = cond_w ? op_a : op_b + 64'd1;
            ALU_CSNEG:  res_w = cond_w ? op_a : ~op_b + 64'd1;
            ALU_PASS_A: res_w = op_a;
            default:    res_w = '0;
        endcase
    end

    // Next-state: capture on issue, otherwise hold data and drop done.
    always_comb begin
        value_d = value_q;
        nzcv_d  = nzcv_q;
        cond_d  = cond_q;
        done_d  = 1'b0;
        if (eu.in_start) begin
            value_d = res_w;
            nzcv_d  = eu.in_set_CC ? {res_w[63], (res_w == 64'd0), c_w, v_w}
                                   : eu.in_prev_nzcv;
            cond_d  = cond_w;
            done_d  = 1'b1;
        end
    end

    // Output registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value_q <= '0;
            nzcv_q  <= '0;
            cond_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            value_q <= value_d;
            nzcv_q  <= nzcv_d;
            cond_q  <= cond_d;
            done_q  <= done_d;
        end
    end

    assign eu.out_fu_value = value_q;
    assign eu.out_fu_nzcv  = nzcv_q;
    assign eu.out_cond_val = cond_q;
    assign eu.out_fu_done  = done_q;

endmodule

// File: tb/tb_arithmetic_execute_unit.sv
// Self-checking bench for arithmetic_execute_unit: a reference model computes
// each op's expected result at issue time into a queue; a monitor pops and
// compares whenever done is expected and checks done is low otherwise.
module tb_arithmetic_execute_unit;
    import arithmetic_execute_unit_pkg::*;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   txn   = 0;

    typedef struct {
        logic [63:0] v;
        logic [3:0]  f;
        logic        c;
    } exp_t;

    exp_t exp_q[$];

    arithmetic_execute_unit_if eu_if ();

    arithmetic_execute_unit dut (
        .clk (clk),
        .rst (rst_n),
        .eu  (eu_if.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic eval_cond(input logic [3:0] cd, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cd)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return c & !z;
            4'd9:  return !(c & !z);
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    function automatic exp_t model(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                                   input logic [5:0] hw, input logic cc, input logic [3:0] cd,
                                   input logic [3:0] prev);
        exp_t e;
        logic [63:0] r;
        logic        c, v, t;
        logic [63:0] mask;
        t = eval_cond(cd, prev);
        c = 1'b0;
        v = 1'b0;
        mask = 64'hFFFF;
        mask = mask << hw;
        case (op)
            5'd0:  begin r = a + b; c = (r < a); v = (a[63] == b[63]) && (r[63] != a[63]); end
            5'd1:  begin r = a - b; c = (a >= b); v = (a[63] != b[63]) && (r[63] != a[63]); end
            5'd2:  r = a & b;
            5'd3:  r = a | b;
            5'd4:  r = a ^ b;
            5'd5:  r = a | ~b;
            5'd6:  r = b << hw;
            5'd7:  r = (a & ~mask) | ((b & 64'hFFFF) << hw);
`ifdef ARITH_EU_SHIFT_EN
            5'd8:  r = a << b[5:0];
            5'd9:  r = a >> b[5:0];
            5'd10: r = 64'($signed(a) >>> b[5:0]);
`endif
            5'd11: r = t ? a : b;
            5'd12: r = t ? a : ~b;
            5'd13: r = t ? a : b + 64'd1;
            5'd14: r = t ? a : 64'd0 - b;
            5'd15: r = a;
            default: r = 64'd0;
        endcase
        e.v = r;
        e.f = cc ? {r[63], (r == 64'd0), c, v} : prev;
        e.c = t;
        return e;
    endfunction

    // Drive one op 4 time units after a rising edge; it is captured at the next edge.
    task automatic issue(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [5:0] hw, input logic cc, input logic [3:0] cd,
                         input logic [3:0] prev);
        @(posedge clk);
        #4;
        eu_if.in_start      = 1'b1;
        eu_if.in_alu_op     = alu_op_t'(op);
        eu_if.in_val_a      = a;
        eu_if.in_val_b      = b;
        eu_if.in_alu_val_hw = hw;
        eu_if.in_set_CC     = cc;
        eu_if.in_cond       = cond_t'(cd);
        eu_if.in_prev_nzcv  = prev;
        exp_q.push_back(model(op, a, b, hw, cc, cd, prev));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #4;
            eu_if.in_start = 1'b0;
        end
    endtask

    // Monitor: 2 time units after each edge, done must match whether an op was captured.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                txn++;
                $display("txn %0d value=%h nzcv=%b cond=%b done=%b", txn,
                         eu_if.out_fu_value, eu_if.out_fu_nzcv, eu_if.out_cond_val, eu_if.out_fu_done);
                check_val("done", 64'(eu_if.out_fu_done), 64'd1);
                check_val("value", eu_if.out_fu_value, e.v);
                check_val("nzcv", 64'(eu_if.out_fu_nzcv), 64'(e.f));
                check_val("cond_val", 64'(eu_if.out_cond_val), 64'(e.c));
            end else begin
                check_val("idle_done", 64'(eu_if.out_fu_done), 64'd0);
            end
        end
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        eu_if.in_start      = 1'b0;
        eu_if.in_alu_op     = ALU_PLUS;
        eu_if.in_val_a      = '0;
        eu_if.in_val_b      = '0;
        eu_if.in_alu_val_hw = '0;
        eu_if.in_set_CC     = 1'b0;
        eu_if.in_cond       = COND_EQ;
        eu_if.in_prev_nzcv  = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        check_val("rst_value", eu_if.out_fu_value, 64'd0);
        check_val("rst_nzcv", 64'(eu_if.out_fu_nzcv), 64'd0);
        check_val("rst_cond", 64'(eu_if.out_cond_val), 64'd0);
        check_val("rst_done", 64'(eu_if.out_fu_done), 64'd0);
        rst_n = 1'b1;

        // Directed cases.
        issue(5'd0, 64'd1, 64'd1, 6'd0, 1'b1, 4'd0, 4'b0000);
        idle(1);
        issue(5'd1, 64'd5, 64'd5, 6'd0, 1'b1, 4'd0, 4'b0000);
        issue(5'd1, 64'd0, 64'd1, 6'd0, 1'b1, 4'd0, 4'b0000);
        issue(5'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 6'd0, 1'b1, 4'd0, 4'b0000);
        issue(5'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 6'd0, 1'b0, 4'd0, 4'b0010);
        issue(5'd7, 64'h1111_2222_3333_4444, 64'hABCD, 6'd16, 1'b0, 4'd0, 4'b0000);
        issue(5'd13, 64'd7, 64'd9, 6'd0, 1'b0, 4'd1, 4'b0100);
        issue(5'd10, 64'h8000_0000_0000_0000, 64'd4, 6'd0, 1'b1, 4'd14, 4'b0000);
        issue(5'd8, 64'h0000_0000_0000_0003, 64'd63, 6'd0, 1'b1, 4'd0, 4'b0000);
        issue(5'd9, 64'hF000_0000_0000_0000, 64'd60, 6'd0, 1'b1, 4'd0, 4'b0000);
        issue(5'd6, 64'd0, 64'hBEEF, 6'd48, 1'b1, 4'd0, 4'b0000);
        issue(5'd14, 64'd3, 64'd1, 6'd0, 1'b1, 4'd12, 4'b1000);
        issue(5'd20, 64'd3, 64'd1, 6'd0, 1'b1, 4'd0, 4'b1111);
        idle(2);

        // Three back-to-back ops.
        issue(5'd2, 64'hFF00_FF00_FF00_FF00, 64'h0FF0_0FF0_0FF0_0FF0, 6'd0, 1'b1, 4'd0, 4'b0000);
        issue(5'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 6'd0, 1'b1, 4'd0, 4'b0000);
        issue(5'd12, 64'd1, 64'd0, 6'd0, 1'b1, 4'd10, 4'b1000);
        idle(2);

        // Randomised ops, including undefined encodings.
        for (int i = 0; i < 40; i++) begin
            logic [63:0] ra, rb;
            ra = {$urandom, $urandom};
            rb = (i % 3 == 0) ? 64'($urandom_range(0, 70)) : {$urandom, $urandom};
            issue(5'($urandom_range(0, 19)), ra, rb, 6'($urandom_range(0, 3) * 16),
                  1'($urandom), 4'($urandom), 4'($urandom));
        end

        // Reset while a result is on the outputs and an op is pending.
        issue(5'd15, 64'hDEAD_BEEF_0000_0001, 64'd0, 6'd0, 1'b1, 4'd0, 4'b0000);
        @(posedge clk);
        #3;
        eu_if.in_start = 1'b0;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_value", eu_if.out_fu_value, 64'd0);
        check_val("mid_rst_nzcv", 64'(eu_if.out_fu_nzcv), 64'd0);
        check_val("mid_rst_done", 64'(eu_if.out_fu_done), 64'd0);
        #1;
        eu_if.in_start      = 1'b1;
        eu_if.in_alu_op     = ALU_PLUS;
        eu_if.in_val_a      = 64'd100;
        eu_if.in_val_b      = 64'd23;
        eu_if.in_set_CC     = 1'b1;
        eu_if.in_cond       = COND_AL;
        eu_if.in_prev_nzcv  = 4'b0000;
        #7;
        check_val("held_rst_value", eu_if.out_fu_value, 64'd0);
        #1;
        rst_n = 1'b1;
        exp_q.push_back(model(5'd0, 64'd100, 64'd23, 6'd0, 1'b1, 4'd14, 4'b0000));
        idle(3);
        issue(5'd3, 64'h0F, 64'hF0, 6'd0, 1'b1, 4'd0, 4'b0000);
        idle(3);

        check_val("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
